// File: rtl/loop_nest_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : loop_nest_sequencer
//  Function : Walks a nest of LEVELS counted loops and streams one index tuple
//             per innermost iteration over valid/ready, with break-at-level
//             and abort. Level 0 is the innermost loop.
//  Option   : LOOP_NEST_SEQUENCER_STEP_EN adds a per-level step input
//             (a latched step of 0 behaves as 1); otherwise every step is 1.
//  Revision : 1.0 - initial release
// ============================================================================
module loop_nest_sequencer #(
   parameter int WIDTH  = 8,
   parameter int LEVELS = 2,
   parameter int CNT_W  = 16,
   localparam int BL_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [LEVELS*WIDTH-1:0] limit,
`ifdef LOOP_NEST_SEQUENCER_STEP_EN
   input  logic [LEVELS*WIDTH-1:0] step,
`endif
   output logic                    iter_valid,
   input  logic                    iter_ready,
   output logic [LEVELS*WIDTH-1:0] iter_idx,
   output logic                    iter_last,
   input  logic                    brk,
   input  logic [BL_W-1:0]         brk_lvl,
   input  logic                    abort,
   output logic                    busy,
   output logic                    done,
   output logic                    aborted,
   output logic [CNT_W-1:0]        iter_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_lim [LEVELS];
   logic [WIDTH-1:0] r_idx [LEVELS];
   logic [WIDTH-1:0] w_step [LEVELS];
   logic [WIDTH-1:0] w_idx_nxt [LEVELS];
   logic [WIDTH:0]   w_sum;
   logic [LEVELS:0]  w_carry;
   logic [LEVELS-1:0] w_wrap;
   logic [31:0]      w_lvl;
   logic             w_acc;
   logic             w_brk_acc;
   logic             w_end;
   logic             w_zero_trip;
   logic [CNT_W-1:0] r_cnt;
   logic             r_aborted;

`ifdef LOOP_NEST_SEQUENCER_STEP_EN
   logic [WIDTH-1:0] r_step [LEVELS];

   // Latch per-level step on launch; a zero step is promoted to one
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < LEVELS; k++) r_step[k] <= WIDTH'(1);
      end else if (r_state == S_IDLE && start) begin
         for (int k = 0; k < LEVELS; k++)
            r_step[k] <= (step[k*WIDTH +: WIDTH] == '0) ? WIDTH'(1) : step[k*WIDTH +: WIDTH];
      end
   end

   // Expose the latched steps to the advance logic
   always_comb begin
      for (int k = 0; k < LEVELS; k++) w_step[k] = r_step[k];
   end
`else
   // Fixed unit step on every level
   always_comb begin
      for (int k = 0; k < LEVELS; k++) w_step[k] = WIDTH'(1);
   end
`endif

   // Detect a zero-trip nest directly from the limit being latched
   always_comb begin
      w_zero_trip = 1'b0;
      for (int k = 0; k < LEVELS; k++)
         if (limit[k*WIDTH +: WIDTH] == '0) w_zero_trip = 1'b1;
   end

   // Carry chain: sums are WIDTH+1 bits so an overflowing step ends the level
   always_comb begin
      w_acc      = (r_state == S_RUN) && iter_ready;
      w_brk_acc  = w_acc && brk;
      w_lvl      = 32'(brk_lvl);
      w_sum      = '0;
      w_carry    = '0;
      w_wrap     = '0;
      w_carry[0] = w_acc && !brk;
      for (int k = 0; k < LEVELS; k++) begin
         w_sum     = {1'b0, r_idx[k]} + {1'b0, w_step[k]};
         w_wrap[k] = (w_sum >= {1'b0, r_lim[k]});
         // A break at level L injects its carry one level above L
         w_carry[k+1] = (w_carry[k] && w_wrap[k]) || (w_brk_acc && (w_lvl == 32'(k)));
         if ((w_brk_acc && (w_lvl >= 32'(k))) || (w_carry[k] && w_wrap[k]))
            w_idx_nxt[k] = '0;
         else if (w_carry[k])
            w_idx_nxt[k] = w_sum[WIDTH-1:0];
         else
            w_idx_nxt[k] = r_idx[k];
      end
      w_end = w_carry[LEVELS] || (w_brk_acc && (w_lvl >= 32'(LEVELS)));
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic; abort has priority over any break or natural end
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (start) w_state_nxt = w_zero_trip ? S_FIN : S_RUN;
         S_RUN: begin
            if (abort)      w_state_nxt = S_IDLE;
            else if (w_end) w_state_nxt = S_FIN;
         end
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Limits, indices, accept counter and abort flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < LEVELS; k++) begin
            r_lim[k] <= '0;
            r_idx[k] <= '0;
         end
         r_cnt     <= '0;
         r_aborted <= 1'b0;
      end else if (r_state == S_IDLE && start) begin
         for (int k = 0; k < LEVELS; k++) begin
            r_lim[k] <= limit[k*WIDTH +: WIDTH];
            r_idx[k] <= '0;
         end
         r_cnt     <= '0;
         r_aborted <= 1'b0;
      end else if (r_state == S_RUN) begin
         if (w_acc && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
         if (abort) r_aborted <= 1'b1;
         else begin
            for (int k = 0; k < LEVELS; k++) r_idx[k] <= w_idx_nxt[k];
         end
      end
   end

   generate
      for (genvar g = 0; g < LEVELS; g++) begin : g_pack
         assign iter_idx[g*WIDTH +: WIDTH] = r_idx[g];
      end
   endgenerate

   assign iter_valid = (r_state == S_RUN);
   assign iter_last  = (r_state == S_RUN) && (&w_wrap);
   assign busy       = (r_state != S_IDLE);
   assign done       = (r_state == S_FIN);
   assign aborted    = r_aborted;
   assign iter_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_loop_nest_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_loop_nest_sequencer
//  Function : Scoreboard bench for loop_nest_sequencer (LEVELS=2, WIDTH=8).
//             Stimulus pushes expected tuples; a monitor pops on each accept.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_loop_nest_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] limit;
`ifdef LOOP_NEST_SEQUENCER_STEP_EN
   logic [15:0] step;
`endif
   logic        iter_valid;
   logic        iter_ready;
   logic [15:0] iter_idx;
   logic        iter_last;
   logic        brk;
   logic [0:0]  brk_lvl;
   logic        abort;
   logic        busy;
   logic        done;
   logic        aborted;
   logic [15:0] iter_count;

   int          n_vec = 0;
   int          n_err = 0;
   logic [16:0] sb_q[$];

   always #5 clk = ~clk;

   loop_nest_sequencer #(.WIDTH(8), .LEVELS(2), .CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .limit      (limit),
`ifdef LOOP_NEST_SEQUENCER_STEP_EN
      .step       (step),
`endif
      .iter_valid (iter_valid),
      .iter_ready (iter_ready),
      .iter_idx   (iter_idx),
      .iter_last  (iter_last),
      .brk        (brk),
      .brk_lvl    (brk_lvl),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted),
      .iter_count (iter_count)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic push(input int i1, input int i0, input bit last);
      sb_q.push_back({last, 8'(i1), 8'(i0)});
   endtask

   // Monitor: compare each accepted tuple and check hold-while-stalled
   initial begin
      logic        held_v;
      logic [15:0] held_idx;
      held_v = 1'b0;
      held_idx = '0;
      forever begin
         @(negedge clk);
         if (held_v && iter_valid) chk("hold_stable", iter_idx, held_idx);
         if (rst_n && iter_valid && iter_ready) begin
            if (sb_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL sb_unexpected: got tuple 0x%0h, expected none", iter_idx);
            end else begin
               chk("tuple", {iter_last, iter_idx}, sb_q.pop_front());
            end
         end
         held_v   = rst_n && iter_valid && !iter_ready;
         held_idx = iter_idx;
      end
   end

   // One run: start, drive ready/brk/abort/reset by accept count, check ending
   task automatic run_case(input string nm, input int rmode, input int brk_at,
                           input logic [0:0] bl, input int abort_at, input int rst_at,
                           input int exp_cnt, input int done_cyc);
      int nacc = 0;
      bit prev_acc = 0;
      bit cur_acc;
      bit saw_v = 0;
      int ev = 0;
      bit fin = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
         iter_ready = (rmode == 0) || (cyc % 2 == 0);
         brk        = (nacc == brk_at);
         brk_lvl    = bl;
         abort      = 1'b0;
         rst_n      = 1'b1;
         if (nacc == abort_at) begin abort = 1'b1; iter_ready = 1'b0; ev = 1; end
         if (nacc == rst_at)   begin rst_n = 1'b0; iter_ready = 1'b0; ev = 2; end
         @(negedge clk);
         cur_acc = iter_valid && iter_ready;
         if (iter_valid) saw_v = 1;
         if (cur_acc) nacc++;
         if (done) begin
            chk({nm, ":done_after_last_accept"}, 64'(prev_acc), 64'(exp_cnt != 0));
            if (done_cyc >= 0) chk({nm, ":done_latency"}, 64'(cyc), 64'(done_cyc));
            if (exp_cnt == 0)  chk({nm, ":valid_never"}, 64'(saw_v), 64'd0);
            chk({nm, ":count"}, iter_count, 64'(exp_cnt));
            chk({nm, ":aborted_clear"}, aborted, 64'd0);
            @(posedge clk); #1;
            iter_ready = 1'b0;
            brk = 1'b0;
            @(negedge clk);
            chk({nm, ":done_one_cycle"}, {done, busy}, 64'd0);
            fin = 1;
         end else if (ev == 1) begin
            @(posedge clk); #1;
            abort = 1'b0;
            @(negedge clk);
            chk({nm, ":abort_state"}, {iter_valid, aborted, done, busy}, 64'b0100);
            chk({nm, ":abort_count"}, iter_count, 64'(exp_cnt));
            fin = 1;
         end else if (ev == 2) begin
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(negedge clk);
            chk({nm, ":reset_outputs"},
                {iter_valid, iter_last, busy, done, aborted, iter_idx, iter_count}, 64'd0);
            fin = 1;
         end
         prev_acc = cur_acc;
         if (!fin) begin @(posedge clk); #1; end
      end
      if (!fin) begin
         n_vec++;
         n_err++;
         $display("FAIL %s:timeout: got no completion, expected done/abort within 300 cycles", nm);
      end
      chk({nm, ":sb_drained"}, 64'(sb_q.size()), 64'd0);
      sb_q.delete();
      iter_ready = 1'b0;
      brk = 1'b0;
      abort = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic push_full_3x4();
      for (int i1 = 0; i1 < 3; i1++)
         for (int i0 = 0; i0 < 4; i0++)
            push(i1, i0, (i1 == 2) && (i0 == 3));
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; limit = '0; iter_ready = 1'b0;
      brk = 1'b0; brk_lvl = '0; abort = 1'b0;
`ifdef LOOP_NEST_SEQUENCER_STEP_EN
      step = '0;
`endif
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_state", {iter_valid, iter_last, busy, done, aborted, iter_idx, iter_count}, 64'd0);

      // Full nest, always ready: (i1,i0) = (0,0)..(2,3)
      limit = {8'd3, 8'd4};
      push_full_3x4();
      run_case("full", 0, -1, 1'b0, -1, -1, 12, -1);

      // Same nest with ready toggling 1,0,1,0
      push_full_3x4();
      run_case("stall", 1, -1, 1'b0, -1, -1, 12, -1);

      // Break level 0 on accepting (1,1): next tuple (2,0); 4+2+4 tuples
      for (int i0 = 0; i0 < 4; i0++) push(0, i0, 0);
      push(1, 0, 0); push(1, 1, 0);
      for (int i0 = 0; i0 < 4; i0++) push(2, i0, i0 == 3);
      run_case("brk_l0", 0, 5, 1'b0, -1, -1, 10, -1);

      // Break level 1 on accepting (0,2): nest ends after three tuples
      push(0, 0, 0); push(0, 1, 0); push(0, 2, 0);
      run_case("brk_l1", 0, 2, 1'b1, -1, -1, 3, -1);

      // Zero-trip outer loop: done right after start, nothing emitted
      limit = {8'd0, 8'd5};
      run_case("zero_trip", 0, -1, 1'b0, -1, -1, 0, 0);

      // Abort after five accepts
      limit = {8'd3, 8'd4};
      push(0, 0, 0); push(0, 1, 0); push(0, 2, 0); push(0, 3, 0); push(1, 0, 0);
      run_case("abort", 0, -1, 1'b0, 5, -1, 5, -1);

      // Restart after abort: flag clears, walk begins at (0,0)
      push_full_3x4();
      run_case("restart", 0, -1, 1'b0, -1, -1, 12, -1);

      // Reset mid-run after three accepts
      push(0, 0, 0); push(0, 1, 0); push(0, 2, 0);
      run_case("reset_mid", 0, -1, 1'b0, -1, 3, 3, -1);

`ifdef LOOP_NEST_SEQUENCER_STEP_EN
      // Inner step 100 under limit 250: 0,100,200 and no wrap to 44
      limit = {8'd1, 8'd250};
      step  = {8'd1, 8'd100};
      push(0, 0, 0); push(0, 100, 0); push(0, 200, 1);
      run_case("step100", 0, -1, 1'b0, -1, -1, 3, -1);
      step  = '0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Absolute time bound on the whole run
   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
